h2f_reg_arbiter: RTL and testbench

H2F_REG_ARBITER -- requirements
Module: h2f_reg_arbiter

---
 rtl/h2f_arb_pkg.sv | 18 +
 rtl/arb_rr2.sv | 32 +++
 rtl/h2f_reg_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_h2f_reg_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h2f_arb_pkg.sv
// Shared types and constants for the HPS/fabric register-port arbiter.
package h2f_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_ABORT  = 3'd3,
        ST_RDERR  = 3'd4
    } arb_state_t;

    localparam logic [63:0] ERR_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; the remembered winner loses the next tie.
module arb_rr2 import h2f_arb_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic [1:0] r_last;

    always_comb begin
        o_grant = GNT_NONE;
        if (i_req == 2'b11) begin
            o_grant = (r_last == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (i_req[0]) begin
            o_grant = GNT_M0;
        end else if (i_req[1]) begin
            o_grant = GNT_M1;
        end
    end

    // Reset value points at m1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= GNT_M1;
        end else if (i_update && (o_grant != GNT_NONE)) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/h2f_reg_arbiter.sv
// Arbitrates the HPS bridge (m0) and a fabric master (m1) onto one register slave,
// with a response timeout that aborts the access and returns error data on reads.
//
// state  | meaning
// IDLE   | no owner; pick a requester and latch grant
// CMD    | granted master's command driven to slave until accepted
// RDWAIT | read accepted, waiting for s_readdatavalid
// ABORT  | timeout: release master's waitrequest, slave command dropped
// RDERR  | timed-out read: return ERR_DATA with readdatavalid
module h2f_reg_arbiter import h2f_arb_pkg::*; #(
    parameter int                      ADDRWIDTH = 10,
    parameter int                      DATAWIDTH = 64,
    parameter int                      TIMEOUT   = 256,
    parameter logic [DATAWIDTH-1:0]    ERR_DATA  = DATAWIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       m0_read,
    input  logic                       m0_write,
    input  logic [ADDRWIDTH-1:0]       m0_address,
    input  logic [DATAWIDTH-1:0]       m0_writedata,
    input  logic [DATAWIDTH/8-1:0]     m0_byteenable,
    output logic [DATAWIDTH-1:0]       m0_readdata,
    output logic                       m0_readdatavalid,
    output logic                       m0_waitrequest,

    input  logic                       m1_read,
    input  logic                       m1_write,
    input  logic [ADDRWIDTH-1:0]       m1_address,
    input  logic [DATAWIDTH-1:0]       m1_writedata,
    input  logic [DATAWIDTH/8-1:0]     m1_byteenable,
    output logic [DATAWIDTH-1:0]       m1_readdata,
    output logic                       m1_readdatavalid,
    output logic                       m1_waitrequest,

    output logic                       s_read,
    output logic                       s_write,
    output logic [ADDRWIDTH-1:0]       s_address,
    output logic [DATAWIDTH-1:0]       s_writedata,
    output logic [DATAWIDTH/8-1:0]     s_byteenable,
    input  logic [DATAWIDTH-1:0]       s_readdata,
    input  logic                       s_readdatavalid,
    input  logic                       s_waitrequest,

    output logic [1:0]                 grant_o,
    output logic                       err_o,
    input  logic                       err_clr_i
);

    localparam int CNTW = ($clog2(TIMEOUT) + 1 > 9) ? $clog2(TIMEOUT) + 1 : 9;

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [1:0]             r_grant;
    logic                   r_op_read;
    logic                   r_err;
    logic [CNTW-1:0]        r_cnt;

    logic [1:0]             w_req;
    logic [1:0]             w_arb_grant;
    logic                   w_take;
    logic                   w_timeout;
    logic                   w_g_read;
    logic                   w_g_write;
    logic [ADDRWIDTH-1:0]   w_g_address;
    logic [DATAWIDTH-1:0]   w_g_writedata;
    logic [DATAWIDTH/8-1:0] w_g_byteenable;
    logic                   w_g_wait;
    logic                   w_g_rdv;
    logic [DATAWIDTH-1:0]   w_g_rdata;

    assign w_req     = {m1_read | m1_write, m0_read | m0_write};
    assign w_take    = (r_state == ST_IDLE) && (w_req != 2'b00);
    assign w_timeout = (r_cnt == CNTW'(TIMEOUT - 1));

    arb_rr2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_update (w_take),
        .o_grant  (w_arb_grant)
    );

    assign w_g_read       = r_grant[1] ? m1_read       : m0_read;
    assign w_g_write      = r_grant[1] ? m1_write      : m0_write;
    assign w_g_address    = r_grant[1] ? m1_address    : m0_address;
    assign w_g_writedata  = r_grant[1] ? m1_writedata  : m0_writedata;
    assign w_g_byteenable = r_grant[1] ? m1_byteenable : m0_byteenable;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= GNT_NONE;
            r_op_read <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_take) begin
                r_grant   <= w_arb_grant;
                r_op_read <= w_arb_grant[1] ? m1_read : m0_read;
            end
            if ((r_state == ST_CMD) || (r_state == ST_RDWAIT)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            // A timeout landing in the same cycle as a clear keeps the flag set.
            if (w_next_state == ST_ABORT) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req != 2'b00) w_next_state = ST_CMD;
            end
            ST_CMD: begin
                if (!s_waitrequest) begin
                    w_next_state = (!r_op_read || s_readdatavalid) ? ST_IDLE : ST_RDWAIT;
                end else if (w_timeout) begin
                    w_next_state = ST_ABORT;
                end
            end
            ST_RDWAIT: begin
                if (s_readdatavalid)  w_next_state = ST_IDLE;
                else if (w_timeout)   w_next_state = ST_ABORT;
            end
            ST_ABORT: w_next_state = r_op_read ? ST_RDERR : ST_IDLE;
            ST_RDERR: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        w_g_wait     = 1'b1;
        w_g_rdv      = 1'b0;
        w_g_rdata    = '0;
        case (r_state)
            ST_CMD: begin
                s_read       = w_g_read;
                s_write      = w_g_write;
                s_address    = w_g_address;
                s_writedata  = w_g_writedata;
                s_byteenable = w_g_byteenable;
                w_g_wait     = s_waitrequest;
                w_g_rdv      = s_readdatavalid;
                w_g_rdata    = s_readdata;
            end
            ST_RDWAIT: begin
                w_g_rdv   = s_readdatavalid;
                w_g_rdata = s_readdata;
            end
            ST_ABORT: w_g_wait = 1'b0;
            ST_RDERR: begin
                w_g_rdv   = 1'b1;
                w_g_rdata = ERR_DATA;
            end
            default: ;
        endcase
    end

    assign m0_waitrequest   = r_grant[0] ? w_g_wait  : 1'b1;
    assign m0_readdatavalid = r_grant[0] & w_g_rdv;
    assign m0_readdata      = r_grant[0] ? w_g_rdata : '0;
    assign m1_waitrequest   = r_grant[1] ? w_g_wait  : 1'b1;
    assign m1_readdatavalid = r_grant[1] & w_g_rdv;
    assign m1_readdata      = r_grant[1] ? w_g_rdata : '0;

    assign grant_o = r_grant;
    assign err_o   = r_err;

endmodule

// File: tb/tb_h2f_reg_arbiter.sv
// Directed and randomized checks of h2f_reg_arbiter against a transaction-level memory model.
module tb_h2f_reg_arbiter;

    localparam int          AW   = 10;
    localparam int          DW   = 64;
    localparam int          TO   = 256;
    localparam logic [63:0] ERRD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          m0_read, m0_write, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [7:0]    m0_byteenable, m1_byteenable, s_byteenable;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic          s_read, s_write;
    logic [1:0]    grant_o;
    logic          err_o, err_clr_i;

    h2f_reg_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
        .grant_o(grant_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge_be(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] be);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Random-phase state: slave memory, reference memory, per-master transaction model
    logic [63:0] smem [1024];
    logic [63:0] refm [1024];
    bit          busy [2];
    bit          rdop [2];
    bit          waitdata [2];
    logic [AW-1:0] taddr [2];
    logic [63:0] tdata [2];
    logic [7:0]  tbe [2];
    int          done [2];
    bit          pend_active;
    int          pend_cnt;
    logic [AW-1:0] pend_addr;

    initial begin
        logic        wt, rv;
        logic [63:0] rdat, v;
        int          lat;

        rst_n = 1'b0;
        m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
        s_readdata = '0; s_readdatavalid = 0; s_waitrequest = 1; err_clr_i = 0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", grant_o, 0);
        check("rst_err", err_o, 0);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        check("rst_m0_rdata", m0_readdata, 0);
        check("rst_m1_rdata", m1_readdata, 0);
        check("rst_s_rw", {s_read, s_write}, 0);

        // m0 single write, slave ready immediately
        @(posedge clk); #1;
        rst_n = 1; m0_write = 1; m0_address = 10'h008;
        m0_writedata = 64'h1122_3344_5566_7788; m0_byteenable = 8'hFF; s_waitrequest = 0;
        #1;
        check("wr_not_early", s_write, 0);
        check("wr_idle_wait", m0_waitrequest, 1);
        @(posedge clk); #2;
        check("wr_s_write", s_write, 1);
        check("wr_s_addr", s_address, 10'h008);
        check("wr_s_data", s_writedata, 64'h1122_3344_5566_7788);
        check("wr_s_be", s_byteenable, 8'hFF);
        check("wr_m0_wait", m0_waitrequest, 0);
        check("wr_m1_wait", m1_waitrequest, 1);
        check("wr_grant", grant_o, 2'b01);
        @(posedge clk); #1;
        m0_write = 0;
        #1;
        check("wr_done_idle", s_write, 0);

        // simultaneous reads after reset: m0 first, then m1
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; m0_read = 1; m0_address = 10'h010; m1_read = 1; m1_address = 10'h020;
        s_waitrequest = 0; s_readdatavalid = 0;
        #1;
        check("rr_idle_m1_wait", m1_waitrequest, 1);
        @(posedge clk); #2;
        check("rr_first_grant", grant_o, 2'b01);
        check("rr_first_addr", s_address, 10'h010);
        check("rr_first_read", s_read, 1);
        check("rr_first_m0_wait", m0_waitrequest, 0);
        check("rr_first_m1_wait", m1_waitrequest, 1);
        @(posedge clk); #1 m0_read = 0;
        #1;
        check("rr_rdwait_m1_wait", m1_waitrequest, 1);
        check("rr_rdwait_s_read", s_read, 0);
        @(posedge clk); #1;
        s_readdatavalid = 1; s_readdata = 64'h0123_4567_89AB_CDEF;
        #1;
        check("rr_m0_rdv", m0_readdatavalid, 1);
        check("rr_m0_rdata", m0_readdata, 64'h0123_4567_89AB_CDEF);
        check("rr_m1_rdv_low", m1_readdatavalid, 0);
        check("rr_m1_wait_held", m1_waitrequest, 1);
        @(posedge clk); #1 s_readdatavalid = 0;
        #1;
        check("rr_idle_gap_read", s_read, 0);
        check("rr_idle_gap_m1_wait", m1_waitrequest, 1);
        @(posedge clk); #2;
        check("rr_second_grant", grant_o, 2'b10);
        check("rr_second_addr", s_address, 10'h020);
        check("rr_second_m1_wait", m1_waitrequest, 0);
        check("rr_second_m0_wait", m0_waitrequest, 1);

        // m1 read completes three cycles after accept
        @(posedge clk); #1 m1_read = 0;
        #1;
        check("lat_rdv_a1", m1_readdatavalid, 0);
        @(posedge clk);
        @(posedge clk); #1;
        s_readdatavalid = 1; s_readdata = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        check("lat_m1_rdv", m1_readdatavalid, 1);
        check("lat_m1_rdata", m1_readdata, 64'hA5A5_A5A5_A5A5_A5A5);
        check("lat_m0_rdv", m0_readdatavalid, 0);
        @(posedge clk); #1 s_readdata = 64'h5A5A_5A5A_5A5A_5A5A;
        #1;
        check("lat_rdv_one_cycle", m1_readdatavalid, 0);
        check("lat_idle_m0_rdv", m0_readdatavalid, 0);

        // m1 write timeout with clear held high: set must win
        @(posedge clk); #1;
        s_readdatavalid = 0; m1_write = 1; m1_address = 10'h3FF; s_waitrequest = 1; err_clr_i = 1;
        repeat (TO) @(posedge clk);
        #2;
        check("towr_last_cmd", s_write, 1);
        check("towr_last_wait", m1_waitrequest, 1);
        check("towr_no_err_yet", err_o, 0);
        @(posedge clk); #2;
        check("towr_abort_wait", m1_waitrequest, 0);
        check("towr_abort_s_write", s_write, 0);
        check("towr_err_set_wins", err_o, 1);
        @(posedge clk); #1 m1_write = 0;
        #1;
        check("towr_err_cleared", err_o, 0);
        check("towr_no_rderr", m1_readdatavalid, 0);

        // m0 read timeout -> ABORT, RDERR with error data, sticky err
        err_clr_i = 0; m0_read = 1; m0_address = 10'h155;
        repeat (TO) @(posedge clk);
        #2;
        check("tord_last_cmd", s_read, 1);
        check("tord_no_err_yet", err_o, 0);
        @(posedge clk); #2;
        check("tord_abort_wait", m0_waitrequest, 0);
        check("tord_abort_s_read", s_read, 0);
        check("tord_abort_err", err_o, 1);
        check("tord_abort_m1_wait", m1_waitrequest, 1);
        @(posedge clk); #1 m0_read = 0;
        #1;
        check("tord_rderr_rdv", m0_readdatavalid, 1);
        check("tord_rderr_data", m0_readdata, ERRD);
        check("tord_rderr_m1_rdv", m1_readdatavalid, 0);
        @(posedge clk); #2;
        check("tord_idle_rdv", m0_readdatavalid, 0);
        repeat (4) @(posedge clk);
        check("tord_err_sticky", err_o, 1);
        err_clr_i = 1;
        @(posedge clk); #1 err_clr_i = 0;
        #1;
        check("tord_err_clr", err_o, 0);

        // reset during RDWAIT abandons the read
        s_waitrequest = 0; m1_read = 1; m1_address = 10'h0AA;
        @(posedge clk); #2;
        check("rstrd_grant", grant_o, 2'b10);
        @(posedge clk); #1;
        m1_read = 0; rst_n = 0;
        @(posedge clk); #1;
        s_readdatavalid = 1; s_readdata = 64'hFEED_FACE_0000_1111;
        #1;
        check("rstrd_grant0", grant_o, 0);
        check("rstrd_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check("rstrd_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        check("rstrd_m1_rdata", m1_readdata, 0);
        check("rstrd_s_rw", {s_read, s_write}, 0);
        check("rstrd_err", err_o, 0);
        @(posedge clk); #1 rst_n = 1;
        #1;
        check("rstrd_late_rdv", m1_readdatavalid, 0);
        check("rstrd_late_rdata", m1_readdata, 0);
        s_readdatavalid = 0;
        m0_write = 1; m0_address = 10'h001; m1_write = 1; m1_address = 10'h002;
        @(posedge clk); #2;
        check("rstrd_m0_first", grant_o, 2'b01);
        @(posedge clk); #1 m0_write = 0;
        @(posedge clk); #2;
        check("rstrd_m1_next", grant_o, 2'b10);
        check("rstrd_m1_wait", m1_waitrequest, 0);
        @(posedge clk); #1 m1_write = 0;

        // randomized traffic from both masters against a memory slave
        for (int a = 0; a < 1024; a++) begin
            v = {$urandom, $urandom};
            smem[a] = v;
            refm[a] = v;
        end
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; waitdata[i] = 0; done[i] = 0;
        end
        pend_active = 0; pend_cnt = 0; pend_addr = '0;

        for (int c = 0; c < 3200; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (c < 3000 && !busy[i] && !waitdata[i] && $urandom_range(0, 2) == 0) begin
                    busy[i]  = 1;
                    rdop[i]  = 1'($urandom_range(0, 1));
                    taddr[i] = AW'($urandom_range(0, 1023));
                    tdata[i] = {$urandom, $urandom};
                    tbe[i]   = 8'($urandom_range(0, 255));
                end
            end
            m0_read = busy[0] & rdop[0]; m0_write = busy[0] & ~rdop[0];
            m0_address = taddr[0]; m0_writedata = tdata[0]; m0_byteenable = tbe[0];
            m1_read = busy[1] & rdop[1]; m1_write = busy[1] & ~rdop[1];
            m1_address = taddr[1]; m1_writedata = tdata[1]; m1_byteenable = tbe[1];
            #1;
            s_readdatavalid = 0;
            if (pend_active) begin
                if (pend_cnt == 0) begin
                    s_readdatavalid = 1;
                    s_readdata = smem[pend_addr];
                    pend_active = 0;
                end else begin
                    pend_cnt--;
                end
            end
            s_waitrequest = 1'($urandom_range(0, 1));
            if (!s_waitrequest && s_write) begin
                smem[s_address] = merge_be(smem[s_address], s_writedata, s_byteenable);
            end else if (!s_waitrequest && s_read) begin
                lat = $urandom_range(0, 3);
                if (lat == 0) begin
                    s_readdatavalid = 1;
                    s_readdata = smem[s_address];
                end else begin
                    pend_active = 1;
                    pend_cnt = lat - 1;
                    pend_addr = s_address;
                end
            end
            #1;
            check("rnd_excl_wait", (!m0_waitrequest && !m1_waitrequest), 0);
            check("rnd_excl_rdv", (m0_readdatavalid && m1_readdatavalid), 0);
            for (int i = 0; i < 2; i++) begin
                wt   = (i == 0) ? m0_waitrequest : m1_waitrequest;
                rv   = (i == 0) ? m0_readdatavalid : m1_readdatavalid;
                rdat = (i == 0) ? m0_readdata : m1_readdata;
                if (!wt) begin
                    check($sformatf("rnd_accept_busy_m%0d", i), busy[i], 1);
                    check($sformatf("rnd_grant_m%0d", i), grant_o, (i == 0) ? 64'h1 : 64'h2);
                    if (busy[i]) begin
                        busy[i] = 0;
                        if (rdop[i]) begin
                            waitdata[i] = 1;
                        end else begin
                            refm[taddr[i]] = merge_be(refm[taddr[i]], tdata[i], tbe[i]);
                            done[i]++;
                        end
                    end
                end
                if (rv) begin
                    check($sformatf("rnd_rdv_expected_m%0d", i), waitdata[i], 1);
                    if (waitdata[i]) begin
                        check($sformatf("rnd_rdata_m%0d", i), rdat, refm[taddr[i]]);
                        waitdata[i] = 0;
                        done[i]++;
                    end
                end
            end
        end

        check("rnd_drained", {busy[0], busy[1], waitdata[0], waitdata[1]}, 0);
        check("rnd_m0_traffic", (done[0] > 20), 1);
        check("rnd_m1_traffic", (done[1] > 20), 1);
        check("rnd_err_quiet", err_o, 0);
        for (int a = 0; a < 1024; a++) begin
            check("rnd_mem_final", smem[a], refm[a]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
